// File: rtl/cam_types.sv
// Shared types and sizing for the CAM datapath and its controller.
package cam_types;
    localparam int unsigned camsize_p = 8;
    localparam int unsigned lru_p     = camsize_p - 1;

    typedef logic [7:0]                     key_t;
    typedef logic [15:0]                    val_t;
    typedef logic [$clog2(camsize_p)-1:0]   idx_t;
    typedef logic [camsize_p-1:0]           one_hot0_t;
    typedef logic [$clog2(camsize_p)-1:0]   lru_t;
    typedef lru_t [camsize_p-1:0]           lru_vec_t;
endpackage

// File: rtl/cam_ctls.sv
// Control/status bundle between the CAM controller and the CAM datapath.
interface CAMCtls;
    import cam_types::*;

    one_hot0_t write_c_d;
    one_hot0_t read_c_d;
    one_hot0_t increment_lru_c_d;
    idx_t      read_idx_c_d;
    one_hot0_t valids_d_c;
    one_hot0_t hits_d_c;
    lru_vec_t  lrus_d_c;

    modport Datapath (
        input  write_c_d, read_c_d, increment_lru_c_d, read_idx_c_d,
        output valids_d_c, hits_d_c, lrus_d_c
    );

    modport Controller (
        output write_c_d, read_c_d, increment_lru_c_d, read_idx_c_d,
        input  valids_d_c, hits_d_c, lrus_d_c
    );
endinterface

// File: rtl/cam_entry.sv
// One CAM entry: valid/key/value/age state, key compare and saturating age.
module cam_entry
    import cam_types::*;
#(
    parameter int unsigned lru_p = cam_types::lru_p
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  key_t key_i,
    input  val_t val_i,
    input  logic write,
    input  logic read,
    input  logic increment,
    output logic hit,
    output logic valid,
    output lru_t age,
    output val_t value
);
    key_t key_q;

    // Write and read both refresh the age, so they take priority over increment.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid <= 1'b0;
            key_q <= '0;
            value <= '0;
            age   <= '0;
        end else if (write) begin
            valid <= 1'b1;
            key_q <= key_i;
            value <= val_i;
            age   <= '0;
        end else if (read) begin
            age <= '0;
        end else if (increment && valid && (age != lru_t'(lru_p))) begin
            age <= age + lru_t'(1);
        end
    end

    assign hit = valid && (key_q == key_i);
endmodule

// File: rtl/cam_datapath.sv
// CAM storage array: parallel key match, per-entry ages, combinational read port.
module cam_datapath #(
    parameter int unsigned camsize_p = cam_types::camsize_p,
    parameter int unsigned lru_p     = cam_types::lru_p
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  cam_types::key_t key_i,
    input  cam_types::val_t val_i,
    output cam_types::val_t val_o,
    CAMCtls.Datapath        ctls
);
    cam_types::val_t values [camsize_p];

    for (genvar i = 0; i < camsize_p; i++) begin : g_entry
        cam_entry #(.lru_p(lru_p)) u_entry (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .key_i     (key_i),
            .val_i     (val_i),
            .write     (ctls.write_c_d[i]),
            .read      (ctls.read_c_d[i]),
            .increment (ctls.increment_lru_c_d[i]),
            .hit       (ctls.hits_d_c[i]),
            .valid     (ctls.valids_d_c[i]),
            .age       (ctls.lrus_d_c[i]),
            .value     (values[i])
        );
    end

    assign val_o = values[ctls.read_idx_c_d];

    // The controller must keep keys unique and select at most one entry per operation.
    a_unique_hit : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $countones(ctls.hits_d_c) <= 1);
    a_onehot_write : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(ctls.write_c_d));
    a_onehot_read : assert property (@(posedge clk_i) disable iff (!reset_n_i)
        $onehot0(ctls.read_c_d));
endmodule

// File: doc/cam_datapath.md
CAM_DATAPATH -- requirements
Module: cam_datapath

Interface
REQ-001 Parameter camsize_p, default 8 (package constant): number of CAM entries.
REQ-002 Parameter lru_p, default camsize_p-1 (package constant): age value that marks an entry as least recently used.
REQ-003 clk_i  input  1  sole clock; all state updates on posedge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 key_i  input  key_t  lookup/write key; compared against all entries every cycle.
REQ-006 val_i  input  val_t  write data.
REQ-007 val_o  output  val_t  read data from the entry selected by ctls.read_idx_c_d.
REQ-008 ctls  CAMCtls.Datapath modport; inputs write_c_d, read_c_d, increment_lru_c_d (one_hot0_t/vector) and read_idx_c_d (idx_t); outputs valids_d_c, hits_d_c (one_hot0_t) and lrus_d_c (array of lru_t).
REQ-009 The design SHALL use one clock, and its reset SHALL be asynchronous and active-low.

Function
REQ-010 Each entry SHALL hold valid (1b), key (key_t), value (val_t) and age (lru_t, $clog2(camsize_p) bits).
REQ-011 valids_d_c[i] SHALL be entry i's valid bit, combinational from state.
REQ-012 hits_d_c[i] SHALL be valid[i] & (key[i] == key_i), combinational, same cycle as key_i.
REQ-013 lrus_d_c[i] SHALL be entry i's age, combinational from state.
REQ-014 val_o SHALL be value[read_idx_c_d], combinational; no read latency.
REQ-015 write_c_d[i]=1 at posedge: valid[i]<=1, key[i]<=key_i, value[i]<=val_i, age[i]<=0.
REQ-016 read_c_d[i]=1 at posedge: age[i]<=0; key, value and valid are unchanged.
REQ-017 increment_lru_c_d[i]=1 at posedge, entry valid: age[i]<=age[i]+1, saturating at lru_p; no wrap to 0.
REQ-018 Increment on an invalid entry SHALL be ignored.
REQ-019 Same entry with write or read and increment in the same cycle: write/read wins (age<=0).
REQ-020 Entries with no control bit set SHALL hold all state.
REQ-021 More than one bit set in write_c_d or in read_c_d SHALL be illegal; each entry still applies REQ-015/016 independently, and an assertion SHALL flag it.
REQ-022 Write to an entry that already holds key_i: value is overwritten, valid stays 1, and no duplicate entry is created (the controller supplies the hit vector).
REQ-023 Duplicate valid keys are illegal; an assertion SHALL fire if $countones(hits_d_c)>1 outside reset.

Reset
REQ-024 reset_n_i low SHALL immediately (asynchronously) clear all valid, key, value and age fields to 0.
REQ-025 During reset, outputs: valids_d_c=0, hits_d_c=0, lrus_d_c all 0, val_o=0.
REQ-026 Reset asserted mid-operation: any pending write is discarded; the first posedge after deassertion applies controls normally.
REQ-027 Assertions SHALL be disabled while reset_n_i is low.

Structure
REQ-028 The package cam_types SHALL hold camsize_p, lru_p, key_t, val_t, idx_t, one_hot0_t and lru_t; the module SHALL declare no local copies.
REQ-029 One sub-module, cam_entry, holds a single entry's state and compare logic; cam_datapath instantiates camsize_p copies by generate.
REQ-030 Age saturation SHALL live only in cam_entry.

Verification
REQ-031 Reset, then key_i=0x00 -> valids_d_c=8'h00, hits_d_c=8'h00, val_o=0.
REQ-032 Write entry 2 with key 0x5A, value 0x1234 (write_c_d=8'h04), then key_i=0x5A, read_idx=2 -> hits_d_c=8'h04, val_o=0x1234, lrus_d_c[2]=0.
REQ-033 Fill all 8 entries, then increment_lru_c_d=8'hFF for 10 cycles -> every age saturates at 7 and none wraps.
REQ-034 Same cycle: write_c_d=8'h08 and increment_lru_c_d=8'hFF with all valid, ages 3 -> age[3]=0, others 4.
REQ-035 Increment_lru_c_d=8'hFF with only entry 0 valid -> age[0]=1, ages 1..7 stay 0.
REQ-036 Assert reset_n_i between clock edges during a write -> state clears immediately and is still 0 after the next posedge.
